// File: rtl/ascii_request_decoder.sv
// ascii_request_decoder
//
// Turns a stream of received ASCII hex command bytes into register-bus
// transactions for the first core of the daisy chain.
//
//   R<aaaa><CR|LF>         -> read  of address aaaa
//   W<aaaa><dddd><CR|LF>   -> write of dddd to address aaaa
//
// Hex digits and the command letter are case-insensitive. A malformed
// command is dropped and flagged with a one-cycle error_o pulse.
//
// Handshake: valid_i is a one-cycle strobe per byte with no ready
// (the UART cannot be stalled); valid_o is a one-cycle strobe per request
// with no ready (the core chain always accepts). Neither side can push back.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   data_i   in   received byte, sampled when valid_i=1
//   valid_i  in   byte strobe
//   addr_o   out  request address (held until the next request)
//   wdata_o  out  request write data, 0 for reads (held)
//   rw_o     out  1 = write, 0 = read (held)
//   valid_o  out  one-cycle request pulse
//   error_o  out  one-cycle discard pulse
module ascii_request_decoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  data_i,
    input  logic        valid_i,
    output logic [15:0] addr_o,
    output logic [15:0] wdata_o,
    output logic        rw_o,
    output logic        valid_o,
    output logic        error_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        TERM = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] addr_buf_q, addr_buf_d;
    logic [15:0] data_buf_q, data_buf_d;
    logic        is_write_q, is_write_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        issue, err;

    logic        is_hex;
    logic [3:0]  nibble;
    logic        is_term;
    logic [7:0]  lower;

    // Letters become lowercase when bit 5 is forced; for the two letters
    // compared against below no non-letter byte aliases onto them.
    assign lower   = data_i | 8'h20;
    assign is_term = (data_i == 8'h0D) || (data_i == 8'h0A);

    always_comb begin
        is_hex = 1'b0;
        nibble = 4'd0;
        if (data_i >= 8'h30 && data_i <= 8'h39) begin
            is_hex = 1'b1;
            nibble = data_i[3:0];
        end else if ((data_i >= 8'h41 && data_i <= 8'h46) ||
                     (data_i >= 8'h61 && data_i <= 8'h66)) begin
            // 'A'/'a' have low nibble 1, so +9 maps A..F onto 10..15
            is_hex = 1'b1;
            nibble = data_i[3:0] + 4'd9;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_buf_d = addr_buf_q;
        data_buf_d = data_buf_q;
        is_write_d = is_write_q;
        cnt_d      = cnt_q;
        issue      = 1'b0;
        err        = 1'b0;

        if (valid_i) begin
            case (state_q)
                IDLE: begin
                    if (lower == 8'h72) begin
                        is_write_d = 1'b0;
                        state_d    = ADDR;
                    end else if (lower == 8'h77) begin
                        is_write_d = 1'b1;
                        state_d    = ADDR;
                    end else if (!is_term) begin
                        err = 1'b1;
                    end
                end
                ADDR: begin
                    if (is_hex) begin
                        addr_buf_d = {addr_buf_q[11:0], nibble};
                        cnt_d      = cnt_q + 2'd1;  // wraps to 0 after the 4th digit
                        if (cnt_q == 2'd3)
                            state_d = is_write_q ? DATA : TERM;
                    end else begin
                        err     = 1'b1;
                        state_d = IDLE;
                    end
                end
                DATA: begin
                    if (is_hex) begin
                        data_buf_d = {data_buf_q[11:0], nibble};
                        cnt_d      = cnt_q + 2'd1;
                        if (cnt_q == 2'd3)
                            state_d = TERM;
                    end else begin
                        err     = 1'b1;
                        state_d = IDLE;
                    end
                end
                TERM: begin
                    if (is_term)
                        issue = 1'b1;
                    else
                        err = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase

            // Every command starts from clean buffers.
            if (state_d == IDLE) begin
                addr_buf_d = 16'd0;
                data_buf_d = 16'd0;
                is_write_d = 1'b0;
                cnt_d      = 2'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_buf_q <= 16'd0;
            data_buf_q <= 16'd0;
            is_write_q <= 1'b0;
            cnt_q      <= 2'd0;
        end else begin
            state_q    <= state_d;
            addr_buf_q <= addr_buf_d;
            data_buf_q <= data_buf_d;
            is_write_q <= is_write_d;
            cnt_q      <= cnt_d;
        end
    end

    // Request outputs load only on issue, so partial or bad commands
    // never disturb the last request presented to the bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_o  <= 16'd0;
            wdata_o <= 16'd0;
            rw_o    <= 1'b0;
            valid_o <= 1'b0;
            error_o <= 1'b0;
        end else begin
            valid_o <= issue;
            error_o <= err;
            if (issue) begin
                addr_o  <= addr_buf_q;
                wdata_o <= is_write_q ? data_buf_q : 16'd0;
                rw_o    <= is_write_q;
            end
        end
    end

endmodule

// File: tb/tb_ascii_request_decoder.sv
// Directed bench for ascii_request_decoder. Bytes are strobed for one
// cycle each; outputs are sampled 1 ns after the rising edge that consumed
// the byte, and pulse counters sample on the falling edge.
module tb_ascii_request_decoder;

    logic        clk;
    logic        rst_n;
    logic [7:0]  data_i;
    logic        valid_i;
    logic [15:0] addr_o;
    logic [15:0] wdata_o;
    logic        rw_o;
    logic        valid_o;
    logic        error_o;

    int n_checks = 0;
    int n_fail   = 0;
    int v_cnt    = 0;
    int e_cnt    = 0;
    int both_cnt = 0;
    int v_base, e_base;

    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;

    ascii_request_decoder dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .data_i  (data_i),
        .valid_i (valid_i),
        .addr_o  (addr_o),
        .wdata_o (wdata_o),
        .rw_o    (rw_o),
        .valid_o (valid_o),
        .error_o (error_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // pulse counters: a pulse stretched past one cycle counts twice
    always @(negedge clk) begin
        if (valid_o) v_cnt++;
        if (error_o) e_cnt++;
        if (valid_o && error_o) both_cnt++;
    end

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // driver tasks: each returns 1 ns after the consuming rising edge
    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        data_i  = b;
        valid_i = 1'b1;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        data_i  = 8'h00;
    endtask

    task automatic send_str(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i]);
            repeat (gap) idle();
        end
    endtask

    task automatic mark();
        v_base = v_cnt;
        e_base = e_cnt;
    endtask

    initial begin
        rst_n   = 1'b0;
        valid_i = 1'b0;
        data_i  = 8'h00;
        repeat (3) idle();
        check("rst_addr",  addr_o,  16'h0000);
        check("rst_wdata", wdata_o, 16'h0000);
        check("rst_rw",    {15'd0, rw_o},    16'd0);
        check("rst_valid", {15'd0, valid_o}, 16'd0);
        check("rst_error", {15'd0, error_o}, 16'd0);
        #3 rst_n = 1'b1;
        repeat (2) idle();

        // read, one byte every 4 cycles
        mark();
        send_str("R1234", 3);
        send_byte(CR);
        check("rd_valid", {15'd0, valid_o}, 16'd1);
        check("rd_addr",  addr_o,  16'h1234);
        check("rd_wdata", wdata_o, 16'h0000);
        check("rd_rw",    {15'd0, rw_o}, 16'd0);
        idle();
        check("rd_valid_drop", {15'd0, valid_o}, 16'd0);
        repeat (2) idle();
        send_byte(LF);
        repeat (3) idle();
        check("rd_vcnt", 16'(v_cnt - v_base), 16'd1);
        check("rd_ecnt", 16'(e_cnt - e_base), 16'd0);

        // lowercase write streamed every cycle
        mark();
        send_str("w0003abCD", 0);
        check("wr_no_early_valid", {15'd0, valid_o}, 16'd0);
        send_byte(LF);
        check("wr_valid", {15'd0, valid_o}, 16'd1);
        check("wr_addr",  addr_o,  16'h0003);
        check("wr_wdata", wdata_o, 16'hABCD);
        check("wr_rw",    {15'd0, rw_o}, 16'd1);
        repeat (5) idle();
        check("wr_hold_addr",  addr_o,  16'h0003);
        check("wr_hold_wdata", wdata_o, 16'hABCD);
        check("wr_vcnt", 16'(v_cnt - v_base), 16'd1);

        // bad digit; the following '4' arrives in IDLE and is a stray byte
        mark();
        send_str("R12G", 0);
        check("bad_err",   {15'd0, error_o}, 16'd1);
        check("bad_valid", {15'd0, valid_o}, 16'd0);
        check("bad_hold_addr",  addr_o,  16'h0003);
        check("bad_hold_wdata", wdata_o, 16'hABCD);
        check("bad_hold_rw",    {15'd0, rw_o}, 16'd1);
        send_str("4", 0);
        send_byte(CR);
        idle();
        check("bad_ecnt", 16'(e_cnt - e_base), 16'd2);
        check("bad_vcnt", 16'(v_cnt - v_base), 16'd0);
        mark();
        send_str("R0005", 0);
        send_byte(CR);
        check("rec_valid", {15'd0, valid_o}, 16'd1);
        check("rec_addr",  addr_o,  16'h0005);
        check("rec_wdata", wdata_o, 16'h0000);
        check("rec_rw",    {15'd0, rw_o}, 16'd0);
        idle();

        // early terminator
        mark();
        send_str("W12", 0);
        send_byte(CR);
        check("early_err",   {15'd0, error_o}, 16'd1);
        check("early_valid", {15'd0, valid_o}, 16'd0);
        // missing terminator
        send_str("R0001", 0);
        send_str("6", 0);
        check("noterm_err",   {15'd0, error_o}, 16'd1);
        check("noterm_valid", {15'd0, valid_o}, 16'd0);
        idle();
        check("term_ecnt", 16'(e_cnt - e_base), 16'd2);
        check("term_vcnt", 16'(v_cnt - v_base), 16'd0);
        check("term_hold_addr", addr_o, 16'h0005);

        // stray bytes in IDLE
        mark();
        send_str("x", 1);
        send_byte(CR);
        send_byte(LF);
        repeat (2) idle();
        check("stray_ecnt", 16'(e_cnt - e_base), 16'd1);
        check("stray_vcnt", 16'(v_cnt - v_base), 16'd0);

        // asynchronous reset in the middle of a write
        mark();
        send_str("W00FF12", 0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_addr",  addr_o,  16'h0000);
        check("arst_wdata", wdata_o, 16'h0000);
        check("arst_rw",    {15'd0, rw_o}, 16'd0);
        check("arst_error", {15'd0, error_o}, 16'd0);
        repeat (2) idle();
        #3 rst_n = 1'b1;
        idle();
        send_str("R00FF", 0);
        send_byte(CR);
        check("post_valid", {15'd0, valid_o}, 16'd1);
        check("post_addr",  addr_o,  16'h00FF);
        check("post_rw",    {15'd0, rw_o}, 16'd0);
        check("post_wdata", wdata_o, 16'h0000);
        repeat (2) idle();
        check("arst_ecnt", 16'(e_cnt - e_base), 16'd0);
        check("arst_vcnt", 16'(v_cnt - v_base), 16'd1);

        check("never_both", 16'(both_cnt), 16'd0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
